digdug_input_cond: RTL and testbench

Input-conditioning stage that sits directly upstream of the DigDug game core's `INP0`/`INP1` ports. It decodes PS/2 key events and merges them with the two HPS joysticks. Coin requests are converted into frame-timed pulses with a hold-off, so the core's coin sampler sees exactly one clean coin per press. The outputs are registered and replace the combinational input wiring in the top level.

---
 rtl/digdug_input_cond.sv | 254 +++++++++++++++++++++++++
 tb/tb_digdug_input_cond.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/digdug_input_cond.sv
// DigDug input conditioning: PS/2 key decode, joystick merge and frame-timed coin pulses.
// Build option: define DIGDUG_PS2KEY_EN to compile in the PS/2 key decoder (joysticks only otherwise).
module digdug_input_cond #(
    parameter int COIN_FRAMES = 4
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic [10:0] ps2_key,
    input  logic [15:0] joystk1,
    input  logic [15:0] joystk2,
    input  logic        vblank,
    input  logic        cabinet,
    input  logic        service,
    output logic [7:0]  INP0,
    output logic [7:0]  INP1
);

    localparam int K_UP1    = 0;
    localparam int K_DOWN1  = 1;
    localparam int K_LEFT1  = 2;
    localparam int K_RIGHT1 = 3;
    localparam int K_FIRE1  = 4;
    localparam int K_F1     = 5;
    localparam int K_F2     = 6;
    localparam int K_START1 = 7;
    localparam int K_START2 = 8;
    localparam int K_COIN1  = 9;
    localparam int K_COIN2  = 10;
    localparam int K_UP2    = 11;
    localparam int K_DOWN2  = 12;
    localparam int K_LEFT2  = 13;
    localparam int K_RIGHT2 = 14;
    localparam int K_FIRE2  = 15;

    localparam logic [3:0] COIN_LIM = 4'(COIN_FRAMES);

    typedef enum logic [1:0] {
        COIN_IDLE    = 2'd0,
        COIN_ACTIVE  = 2'd1,
        COIN_HOLDOFF = 2'd2
    } coin_state_e;

    logic [15:0] key_vec;

`ifdef DIGDUG_PS2KEY_EN
    logic        key_tog_q;
    logic        key_tog_d;
    logic        key_evt;
    logic        key_pressed;
    logic        key_ext;
    logic [7:0]  key_code;
    logic [15:0] key_q;
    logic [15:0] key_d;

    always_comb begin
        key_tog_d   = ps2_key[10];
        key_evt     = (ps2_key[10] != key_tog_q);
        key_pressed = ps2_key[9];
        key_ext     = ps2_key[8];
        key_code    = ps2_key[7:0];
        key_d       = key_q;
        if (key_evt) begin
            // Arrow keys match on both scan-code pages; everything else needs page 0
            case (key_code)
                8'h75:   key_d[K_UP1]    = key_pressed;
                8'h72:   key_d[K_DOWN1]  = key_pressed;
                8'h6B:   key_d[K_LEFT1]  = key_pressed;
                8'h74:   key_d[K_RIGHT1] = key_pressed;
                default: begin
                    if (!key_ext) begin
                        case (key_code)
                            8'h29, 8'h14: key_d[K_FIRE1]  = key_pressed;
                            8'h05:        key_d[K_F1]     = key_pressed;
                            8'h06:        key_d[K_F2]     = key_pressed;
                            8'h16:        key_d[K_START1] = key_pressed;
                            8'h1E:        key_d[K_START2] = key_pressed;
                            8'h2E:        key_d[K_COIN1]  = key_pressed;
                            8'h36:        key_d[K_COIN2]  = key_pressed;
                            8'h2D:        key_d[K_UP2]    = key_pressed;
                            8'h2B:        key_d[K_DOWN2]  = key_pressed;
                            8'h23:        key_d[K_LEFT2]  = key_pressed;
                            8'h34:        key_d[K_RIGHT2] = key_pressed;
                            8'h1C, 8'h1B: key_d[K_FIRE2]  = key_pressed;
                            default:      ;
                        endcase
                    end
                end
            endcase
        end
    end

    // The toggle copy tracks the input even in reset so release never looks like an event
    always_ff @(posedge clk_sys) begin
        key_tog_q <= key_tog_d;
        if (!reset_n) begin
            key_q <= '0;
        end else begin
            key_q <= key_d;
        end
    end

    assign key_vec = key_q;
`else
    logic unused_ps2_key;
    assign unused_ps2_key = ^ps2_key;
    assign key_vec        = '0;
`endif

    logic unused_joy_hi;
    assign unused_joy_hi = ^{joystk1[15:8], joystk2[15:8]};

    // Frame tick: one-cycle pulse after vblank is seen rising
    logic vblank_q;
    logic vblank_d;
    logic tick_q;
    logic tick_d;

    always_comb begin
        vblank_d = vblank;
        tick_d   = vblank & ~vblank_q;
    end

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            vblank_q <= 1'b0;
            tick_q   <= 1'b0;
        end else begin
            vblank_q <= vblank_d;
            tick_q   <= tick_d;
        end
    end

    logic       p2_up, p2_down, p2_left, p2_right, p2_fire;
    logic       p1_up, p1_down, p1_left, p1_right, p1_fire;
    logic       start1, start2;
    logic [1:0] coin_req;
    logic [1:0] coin_bit;

    always_comb begin
        p2_up    = key_vec[K_UP2]    | joystk2[3];
        p2_down  = key_vec[K_DOWN2]  | joystk2[2];
        p2_left  = key_vec[K_LEFT2]  | joystk2[1];
        p2_right = key_vec[K_RIGHT2] | joystk2[0];
        p2_fire  = key_vec[K_FIRE2]  | joystk2[4];

        // Upright cabinets let either player's controls drive player 1
        p1_up    = key_vec[K_UP1]    | joystk1[3] | (~cabinet & p2_up);
        p1_down  = key_vec[K_DOWN1]  | joystk1[2] | (~cabinet & p2_down);
        p1_left  = key_vec[K_LEFT1]  | joystk1[1] | (~cabinet & p2_left);
        p1_right = key_vec[K_RIGHT1] | joystk1[0] | (~cabinet & p2_right);
        p1_fire  = key_vec[K_FIRE1]  | joystk1[4] | (~cabinet & p2_fire);

        start1 = key_vec[K_F1] | key_vec[K_START1] | joystk1[5] | joystk2[5];
        start2 = key_vec[K_F2] | key_vec[K_START2] | joystk1[6] | joystk2[6];

        coin_req[0] = key_vec[K_F1] | key_vec[K_COIN1] | joystk1[7];
        coin_req[1] = key_vec[K_F2] | key_vec[K_COIN2] | joystk2[7];
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_coin
            coin_state_e state_q;
            coin_state_e state_d;
            logic [3:0]  cnt_q;
            logic [3:0]  cnt_d;
            logic        req_prev_q;
            logic        req_prev_d;
            logic        req_rise;
            logic        coin_on;

            always_ff @(posedge clk_sys) begin
                if (!reset_n) begin
                    state_q    <= COIN_IDLE;
                    cnt_q      <= '0;
                    req_prev_q <= 1'b0;
                end else begin
                    state_q    <= state_d;
                    cnt_q      <= cnt_d;
                    req_prev_q <= req_prev_d;
                end
            end

            // Edges outside IDLE are dropped; the history still tracks so a held request cannot retrigger
            always_comb begin
                req_prev_d = coin_req[gi];
                req_rise   = coin_req[gi] & ~req_prev_q;
                state_d    = state_q;
                cnt_d      = cnt_q;
                case (state_q)
                    COIN_IDLE: begin
                        if (req_rise) begin
                            state_d = COIN_ACTIVE;
                            cnt_d   = '0;
                        end
                    end
                    COIN_ACTIVE: begin
                        if (tick_q) begin
                            if (cnt_q + 4'd1 == COIN_LIM) begin
                                state_d = COIN_HOLDOFF;
                                cnt_d   = '0;
                            end else begin
                                cnt_d = cnt_q + 4'd1;
                            end
                        end
                    end
                    COIN_HOLDOFF: begin
                        if (tick_q) begin
                            if (cnt_q + 4'd1 == COIN_LIM) begin
                                state_d = COIN_IDLE;
                                cnt_d   = '0;
                            end else begin
                                cnt_d = cnt_q + 4'd1;
                            end
                        end
                    end
                    default: begin
                        state_d = COIN_IDLE;
                        cnt_d   = '0;
                    end
                endcase
            end

            always_comb begin
                coin_on = (state_q == COIN_ACTIVE);
            end

            assign coin_bit[gi] = coin_on;
        end
    endgenerate

    logic [7:0] inp0_q;
    logic [7:0] inp0_d;
    logic [7:0] inp1_q;
    logic [7:0] inp1_d;

    always_comb begin
        inp0_d = {service, 1'b0, coin_bit[1], coin_bit[0], start2, start1, p2_fire, p1_fire};
        inp1_d = {p2_left, p2_down, p2_right, p2_up, p1_left, p1_down, p1_right, p1_up};
    end

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            inp0_q <= 8'h00;
            inp1_q <= 8'h00;
        end else begin
            inp0_q <= inp0_d;
            inp1_q <= inp1_d;
        end
    end

    assign INP0 = inp0_q;
    assign INP1 = inp1_q;

endmodule

// File: tb/tb_digdug_input_cond.sv
// Scoreboard bench for digdug_input_cond: a cycle-level reference model predicts INP0/INP1,
// a separate monitor compares every cycle.
module tb_digdug_input_cond;

    localparam int CF        = 4;
    localparam int FRAME_CYC = 10;
`ifdef DIGDUG_PS2KEY_EN
    localparam bit KEYS_ON = 1'b1;
`else
    localparam bit KEYS_ON = 1'b0;
`endif

    localparam int I_UP1 = 0, I_DOWN1 = 1, I_LEFT1 = 2, I_RIGHT1 = 3, I_FIRE1 = 4;
    localparam int I_F1 = 5, I_F2 = 6, I_START1 = 7, I_START2 = 8, I_COIN1 = 9, I_COIN2 = 10;
    localparam int I_UP2 = 11, I_DOWN2 = 12, I_LEFT2 = 13, I_RIGHT2 = 14, I_FIRE2 = 15;
    localparam int NCODES = 27;

    logic        clk_sys = 1'b0;
    logic        reset_n;
    logic [10:0] ps2_key;
    logic [15:0] joystk1;
    logic [15:0] joystk2;
    logic        vblank;
    logic        cabinet;
    logic        service;
    logic [7:0]  INP0;
    logic [7:0]  INP1;

    always #5 clk_sys = ~clk_sys;

    digdug_input_cond #(.COIN_FRAMES(CF)) dut (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .ps2_key (ps2_key),
        .joystk1 (joystk1),
        .joystk2 (joystk2),
        .vblank  (vblank),
        .cabinet (cabinet),
        .service (service),
        .INP0    (INP0),
        .INP1    (INP1)
    );

    typedef struct {
        int         due;
        logic [7:0] e0;
        logic [7:0] e1;
    } exp_t;

    exp_t sb_q[$];
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;
    int   fcnt  = 0;

    // Reference model state
    bit key_m [16];
    bit tog_m;
    bit vb_m;
    bit tick_m;
    bit req_prev_m [2];
    int ticks_left_m [2];   // 2*CF..CF+1: pulse high, CF..1: hold-off, 0: ready

    logic [8:0] codes [NCODES] = '{9'h075, 9'h175, 9'h072, 9'h172, 9'h06B, 9'h16B, 9'h074,
                                   9'h174, 9'h029, 9'h014, 9'h114, 9'h005, 9'h006, 9'h016,
                                   9'h01E, 9'h02E, 9'h036, 9'h12E, 9'h02D, 9'h02B, 9'h023,
                                   9'h034, 9'h01C, 9'h01B, 9'h11C, 9'h055, 9'h000};

    function automatic int key_index(input logic [8:0] code);
        logic [7:0] lo;
        lo = code[7:0];
        if (lo == 8'h75) return I_UP1;
        if (lo == 8'h72) return I_DOWN1;
        if (lo == 8'h6B) return I_LEFT1;
        if (lo == 8'h74) return I_RIGHT1;
        if (code[8]) return -1;
        case (lo)
            8'h29, 8'h14: return I_FIRE1;
            8'h05:        return I_F1;
            8'h06:        return I_F2;
            8'h16:        return I_START1;
            8'h1E:        return I_START2;
            8'h2E:        return I_COIN1;
            8'h36:        return I_COIN2;
            8'h2D:        return I_UP2;
            8'h2B:        return I_DOWN2;
            8'h23:        return I_LEFT2;
            8'h34:        return I_RIGHT2;
            8'h1C, 8'h1B: return I_FIRE2;
            default:      return -1;
        endcase
    endfunction

    function automatic bit km(input int i);
        return KEYS_ON && key_m[i];
    endfunction

    // One clock of stimulus: predict the registered outputs, advance the model, then clock
    task automatic step();
        exp_t e;
        bit   u2, d2, l2, r2, f2p, u1, d1, l1, r1, f1p, s1, s2;
        bit   req [2];
        bit   evt, new_tick;
        int   idx;
        vblank = ((fcnt % FRAME_CYC) < 2) ? 1'b1 : 1'b0;
        fcnt++;

        u2  = km(I_UP2)    || joystk2[3];
        d2  = km(I_DOWN2)  || joystk2[2];
        l2  = km(I_LEFT2)  || joystk2[1];
        r2  = km(I_RIGHT2) || joystk2[0];
        f2p = km(I_FIRE2)  || joystk2[4];
        u1  = km(I_UP1)    || joystk1[3] || (!cabinet && u2);
        d1  = km(I_DOWN1)  || joystk1[2] || (!cabinet && d2);
        l1  = km(I_LEFT1)  || joystk1[1] || (!cabinet && l2);
        r1  = km(I_RIGHT1) || joystk1[0] || (!cabinet && r2);
        f1p = km(I_FIRE1)  || joystk1[4] || (!cabinet && f2p);
        s1  = km(I_F1) || km(I_START1) || joystk1[5] || joystk2[5];
        s2  = km(I_F2) || km(I_START2) || joystk1[6] || joystk2[6];
        req[0] = km(I_F1) || km(I_COIN1) || joystk1[7];
        req[1] = km(I_F2) || km(I_COIN2) || joystk2[7];

        e.due = cyc + 1;
        if (!reset_n) begin
            e.e0 = 8'h00;
            e.e1 = 8'h00;
        end else begin
            e.e0 = {service, 1'b0, ticks_left_m[1] > CF, ticks_left_m[0] > CF, s2, s1, f2p, f1p};
            e.e1 = {l2, d2, r2, u2, l1, d1, r1, u1};
        end
        sb_q.push_back(e);

        evt      = (ps2_key[10] != tog_m);
        tog_m    = ps2_key[10];
        new_tick = vblank && !vb_m;
        if (!reset_n) begin
            for (int i = 0; i < 16; i++) key_m[i] = 1'b0;
            for (int i = 0; i < 2; i++) begin
                ticks_left_m[i] = 0;
                req_prev_m[i]   = 1'b0;
            end
            vb_m   = 1'b0;
            tick_m = 1'b0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (ticks_left_m[i] == 0) begin
                    if (req[i] && !req_prev_m[i]) ticks_left_m[i] = 2 * CF;
                end else if (tick_m) begin
                    ticks_left_m[i]--;
                end
                req_prev_m[i] = req[i];
            end
            if (evt) begin
                idx = key_index(ps2_key[8:0]);
                if (idx >= 0) key_m[idx] = ps2_key[9];
            end
            vb_m   = vblank;
            tick_m = new_tick;
        end

        @(posedge clk_sys);
        cyc++;
        #1;
    endtask

    task automatic hold(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic send_key(input bit pressed, input logic [8:0] code);
        ps2_key = {~ps2_key[10], pressed, code};
        step();
    endtask

    task automatic coin_tap(input int len);
        joystk1 = 16'h0080;
        hold(len);
        joystk1 = 16'h0000;
    endtask

    // Monitor: one comparison line per output whenever a prediction falls due
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_sys);
            while (sb_q.size() > 0 && sb_q[0].due < cyc) begin
                e = sb_q.pop_front();
                total++;
                bad++;
                $display("FAIL stale cyc=%0d got=none want=due%0d", cyc, e.due);
            end
            if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
                e = sb_q.pop_front();
                total++;
                if (INP0 !== e.e0) begin
                    bad++;
                    $display("FAIL inp0 cyc=%0d got=%02h want=%02h", cyc, INP0, e.e0);
                end
                total++;
                if (INP1 !== e.e1) begin
                    bad++;
                    $display("FAIL inp1 cyc=%0d got=%02h want=%02h", cyc, INP1, e.e1);
                end
            end
        end
    end

    initial begin
        reset_n = 1'b0;
        ps2_key = 11'h400;
        joystk1 = 16'h0000;
        joystk2 = 16'h0000;
        cabinet = 1'b0;
        service = 1'b0;
        vblank  = 1'b0;
        tog_m   = 1'b0;
        vb_m    = 1'b0;
        tick_m  = 1'b0;
        for (int i = 0; i < 16; i++) key_m[i] = 1'b0;
        for (int i = 0; i < 2; i++) begin
            ticks_left_m[i] = 0;
            req_prev_m[i]   = 1'b0;
        end

        // Reset with the toggle bit high, then idle
        hold(3);
        reset_n = 1'b1;
        hold(10);

        // Arrow up on both scan-code pages
        send_key(1'b1, 9'h075); hold(6);
        send_key(1'b0, 9'h075); hold(6);
        send_key(1'b1, 9'h175); hold(6);
        send_key(1'b0, 9'h175); hold(6);

        // Player 2 up merged into player 1 only when upright
        joystk2 = 16'h0008; cabinet = 1'b0; hold(4);
        cabinet = 1'b1; hold(4);
        joystk2 = 16'h0000; cabinet = 1'b0; hold(2);

        // Coin held for 20 frames, then released and pressed again
        coin_tap(20 * FRAME_CYC); hold(50);
        coin_tap(100); hold(100);

        // Two taps two frames apart, then both coins together
        coin_tap(3); hold(2 * FRAME_CYC);
        coin_tap(3); hold(100);
        joystk1 = 16'h0080; joystk2 = 16'h0080; hold(100);
        joystk1 = 16'h0000; joystk2 = 16'h0000; hold(100);

        // Reset in the middle of a pulse, then a fresh press
        joystk1 = 16'h0080; hold(15);
        reset_n = 1'b0; hold(1);
        reset_n = 1'b1; hold(5);
        joystk1 = 16'h0000; hold(100);
        coin_tap(100); hold(100);

        // Coin via F1 key
        send_key(1'b1, 9'h005); hold(5);
        send_key(0, 9'h005); hold(100);

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(7) == 0) joystk1 = 16'($urandom & $urandom & $urandom);
            if ($urandom_range(7) == 0) joystk2 = 16'($urandom & $urandom & $urandom);
            if ($urandom_range(49) == 0) cabinet = ~cabinet;
            if ($urandom_range(29) == 0) service = ~service;
            reset_n = ($urandom_range(499) != 0) ? 1'b1 : 1'b0;
            if ($urandom_range(9) == 0) begin
                int k;
                k = int'($urandom_range(NCODES - 1));
                ps2_key = {~ps2_key[10], 1'($urandom_range(1)), codes[k]};
            end
            step();
        end
        reset_n = 1'b1;
        joystk1 = 16'h0000;
        joystk2 = 16'h0000;
        hold(4);

        repeat (2) @(negedge clk_sys);
        #1;
        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL drain got=%0d pending want=0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
